// File: rtl/name_match_logger_if.sv
// Bus between the name-match logger and its host: detector-side strobes in,
// FIFO head / status out.
interface name_match_logger_if #(
  parameter int POS_W = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             chr_valid;
  logic             match;
  logic             rd_en;
  logic             clr_ovf;
  logic [POS_W-1:0] rd_data;
  logic             empty;
  logic             full;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] match_count;

  // host / scoreboard side
  modport master (
    output chr_valid, match, rd_en, clr_ovf,
    input  rd_data, empty, full, level, overflow, match_count
  );

  // logger side
  modport slave (
    input  chr_valid, match, rd_en, clr_ovf,
    output rd_data, empty, full, level, overflow, match_count
  );
endinterface

// File: rtl/name_match_logger.sv
// Logs the character index at which the name detector fired. A running index
// of presented characters is delayed by MATCH_LAG clocks so that it lines up
// with the match pulse, then pushed into a first-word-fall-through FIFO.
// A saturating counter tracks every match, including ones dropped when full.
module name_match_logger #(
  parameter int POS_W     = 16,
  parameter int DEPTH     = 8,
  parameter int MATCH_LAG = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  name_match_logger_if.slave   bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  // keep at least one pipeline stage declared so MATCH_LAG=0 still elaborates
  localparam int LAG_N = (MATCH_LAG == 0) ? 1 : MATCH_LAG;

  logic [POS_W-1:0] pos_cnt_q, pos_cnt_d;
  logic [POS_W-1:0] lag_q [LAG_N];
  logic [POS_W-1:0] lag_d [LAG_N];
  logic [POS_W-1:0] tag;

  logic [POS_W-1:0] mem_q [DEPTH];
  logic [POS_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_empty;
  logic is_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // flags come only from registered occupancy
  assign is_empty = (level_q == '0);
  assign is_full  = (level_q == LW'(DEPTH));

  // a pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_pop  = bus.rd_en & ~is_empty;
  assign do_push = bus.match & (~is_full | do_pop);
  assign do_drop = bus.match & ~do_push;

  // index of the character currently on chr_valid; wraps silently
  always_comb begin
    pos_cnt_d = pos_cnt_q + POS_W'(bus.chr_valid);
  end

  // free-running delay line (not gated by chr_valid) to align with the match pulse
  always_comb begin
    lag_d[0] = pos_cnt_q;
    for (int i = 1; i < LAG_N; i++) begin
      lag_d[i] = lag_q[i-1];
    end
  end

  assign tag = (MATCH_LAG == 0) ? pos_cnt_q : lag_q[LAG_N-1];

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = tag;
    end
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
  end

  // saturating match counter and sticky overflow; a drop beats a clear
  always_comb begin
    cnt_d = cnt_q;
    if (bus.match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    ovf_d = ovf_q;
    if (do_drop) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // state registers; reset discards every logged entry and ignores inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_cnt_q <= '0;
      for (int i = 0; i < LAG_N; i++) begin
        lag_q[i] <= '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pos_cnt_q <= pos_cnt_d;
      lag_q     <= lag_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.rd_data     = mem_q[rd_ptr_q];
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.level       = level_q;
  assign bus.overflow    = ovf_q;
  assign bus.match_count = cnt_q;

endmodule
